mem_arb_n: RTL and testbench
============================

Name: mem_arb_n

Overview:
- Parametrised N-client memory arbiter; successor to the fixed two-client (stim read / check write) memory interface.
- Multiplexes NUM_PORTS Avalon-style clients onto one memory master port, which feeds the SRAM arbiter.
- Supports round-robin or fixed-priority mode and sticky grants during stalls.
- Routes pipelined read responses back to the issuing client via an in-order tag FIFO.

Parameters:
- NUM_PORTS, 2, number of client ports (2..8).
- ADDR_WIDTH, 20, address width.
- DATA_WIDTH, 16, data width; must be a multiple of 8.
- BE_WIDTH, DATA_WIDTH/8, byteenable width.
- MAX_PENDING, 4, depth of the outstanding-read tag FIFO (power of 2, ≥2).
- PRIORITY_MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority with port 0 highest.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cl_address  in  NUM_PORTS*ADDR_WIDTH  client addresses, port i at slice i.
- cl_byteenable  in  NUM_PORTS*BE_WIDTH  client byteenables.
- cl_read  in  NUM_PORTS  client read requests.
- cl_write  in  NUM_PORTS  client write requests.
- cl_writedata  in  NUM_PORTS*DATA_WIDTH  client write data.
- cl_waitrequest  out  NUM_PORTS  per-client stall.
- cl_readdata  out  DATA_WIDTH  read data, broadcast to all clients.
- cl_readdataready  out  NUM_PORTS  per-client read-data valid.
- mem_address  out  ADDR_WIDTH  master address.
- mem_byteenable  out  BE_WIDTH  master byteenable.
- mem_read  out  1  master read.
- mem_write  out  1  master write.
- mem_writedata  out  DATA_WIDTH  master write data.
- mem_waitrequest  in  1  memory stall.
- mem_readdata  in  DATA_WIDTH  memory read data.
- mem_readdataready  in  1  memory read-data valid.
- pending_count  out  $clog2(MAX_PENDING+1)  number of outstanding reads.
- err_orphan  out  1  sticky flag: read data returned with no outstanding read.

Behaviour:
- Reset (async, immediate):
  - rr pointer = 0; lock cleared; tag FIFO empty; pending_count = 0; err_orphan = 0.
  - cl_readdataready all 0; cl_waitrequest all 1; mem_read/mem_write = 0; mem_address/byteenable/writedata = 0.
- Request: client i requests when cl_read[i] | cl_write[i]. Simultaneous read and write on one client is illegal; write wins.
- Read eligibility: if the tag FIFO is full, read requests are ineligible. Write requests remain eligible.
- Winner selection (combinational, same cycle):
  - Lock held: winner = locked port.
  - Otherwise, mode 0: first eligible port at or after rr pointer, with wrap-around.
  - Otherwise, mode 1: lowest-index eligible port.
- Master outputs: mem_* driven from the winner's slices, zero-latency pass-through. With no winner, mem_read = mem_write = 0 and mem data fields = 0.
- Waitrequest: cl_waitrequest[i] = ~(winner==i) | mem_waitrequest, and is 1 for any non-winner.
- Accept: a transfer is accepted in a cycle where (mem_read | mem_write) & ~mem_waitrequest.
- Lock:
  - Set when the winner is presented and mem_waitrequest = 1.
  - Cleared on accept, or if the locked client drops its request (protocol violation; winner is reselected next cycle).
- Pointer update: on accept in mode 0, rr pointer ← (winner+1) mod NUM_PORTS. Mode 1 ignores the pointer.
- Tag FIFO:
  - Read accept pushes the winner index.
  - mem_readdataready pops the head h: cl_readdataready[h] = 1 for that same cycle (combinational) and cl_readdata = mem_readdata.
  - Push and pop in the same cycle are both performed; count unchanged.
  - Data is returned strictly in order.
- Orphan data: mem_readdataready with the FIFO empty (and no same-cycle push) sets err_orphan. No cl_readdataready is asserted and the FIFO is unchanged. err_orphan clears only on reset.
- pending_count: registered, equals FIFO occupancy.
- Back-to-back: one accept per cycle sustained when mem_waitrequest = 0.

Test Plan:
- Reset mid-operation: reset asserted with lock held and 2 reads pending → outputs immediately at reset values; after release, a port-0 read issues with tag 0 and is returned to port 0.
- Round-robin fairness: NUM_PORTS=3, all ports hold a continuous write, mem_waitrequest=0 → grant sequence 0,1,2,0,1,2 on consecutive cycles; mem_address matches each port's slice.
- Fixed priority: PRIORITY_MODE=1, ports 1 and 2 request, port 0 asserts at cycle 3 → grants 1,1,0 from cycle 3 on; port 2 starved while port 1 requests.
- Sticky grant: port 1 write wins with mem_waitrequest=1 for 3 cycles while port 0 also requests → mem_address stays at port 1's address; grant passes to port 0 on the cycle after accept.
- Read routing / full FIFO: MAX_PENDING=4, reads from ports 2,0,1,0 accepted, then a 5th read from port 1 → port 1 waitrequest=1 and pending_count=4; a port-0 write in the same window is still accepted. Readdataready pulses then go to ports 2,0,1,0 in order, and port 1's 5th read issues on the cycle after the first pop.
- Orphan and simultaneous push/pop: mem_readdataready with no pending read → err_orphan=1, no client strobe. Read accept and return in the same cycle with pending_count=1 → count stays at 1 and the head tag is delivered.

Source files
------------

// File: rtl/mem_arb_n.sv
// N-client Avalon-style memory arbiter: round-robin or fixed-priority selection,
// sticky grants while the memory stalls, and in-order read-response routing by tag FIFO.
module mem_arb_n #(
  parameter int NUM_PORTS     = 2,
  parameter int ADDR_WIDTH    = 20,
  parameter int DATA_WIDTH    = 16,
  parameter int BE_WIDTH      = DATA_WIDTH / 8,
  parameter int MAX_PENDING   = 4,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  cl_address,
  input  logic [NUM_PORTS*BE_WIDTH-1:0]    cl_byteenable,
  input  logic [NUM_PORTS-1:0]             cl_read,
  input  logic [NUM_PORTS-1:0]             cl_write,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  cl_writedata,
  output logic [NUM_PORTS-1:0]             cl_waitrequest,
  output logic [DATA_WIDTH-1:0]            cl_readdata,
  output logic [NUM_PORTS-1:0]             cl_readdataready,
  output logic [ADDR_WIDTH-1:0]            mem_address,
  output logic [BE_WIDTH-1:0]              mem_byteenable,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic [DATA_WIDTH-1:0]            mem_writedata,
  input  logic                             mem_waitrequest,
  input  logic [DATA_WIDTH-1:0]            mem_readdata,
  input  logic                             mem_readdataready,
  output logic [$clog2(MAX_PENDING+1)-1:0] pending_count,
  output logic                             err_orphan
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int FW = $clog2(MAX_PENDING);
  localparam int CW = $clog2(MAX_PENDING + 1);

  logic [PW-1:0] rrPtr_q, rrPtr_d;
  logic          lock_q, lock_d;
  logic [PW-1:0] lockPort_q, lockPort_d;
  logic [PW-1:0] tagMem_q [MAX_PENDING];
  logic [FW-1:0] wrPtr_q, wrPtr_d;
  logic [FW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          orphan_q, orphan_d;

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] eligible;
  logic                 fifoFull;
  logic                 fifoEmpty;
  logic                 winValid;
  logic [PW-1:0]        winner;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic [PW-1:0]        headTag;

  assign fifoFull  = (count_q == CW'(MAX_PENDING));
  assign fifoEmpty = (count_q == '0);

  // A full tag FIFO blocks reads only; writes keep competing.
  always_comb begin
    req      = '0;
    eligible = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      req[i]      = cl_read[i] | cl_write[i];
      eligible[i] = cl_write[i] | (cl_read[i] & ~fifoFull);
    end
  end

  // Loops run backwards so the lowest index / smallest rr offset is assigned last and wins.
  always_comb begin
    int idx;
    idx      = 0;
    winValid = 1'b0;
    winner   = '0;
    if (lock_q) begin
      winValid = req[lockPort_q];
      winner   = lockPort_q;
    end else if (PRIORITY_MODE == 1) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (eligible[i]) begin
          winValid = 1'b1;
          winner   = PW'(i);
        end
      end
    end else begin
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
        idx = (int'(rrPtr_q) + k) % NUM_PORTS;
        if (eligible[idx]) begin
          winValid = 1'b1;
          winner   = PW'(idx);
        end
      end
    end
    if (reset) winValid = 1'b0;
  end

  always_comb begin
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    if (winValid) begin
      mem_write      = cl_write[winner];
      mem_read       = cl_read[winner] & ~cl_write[winner];
      mem_address    = cl_address[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
      mem_byteenable = cl_byteenable[int'(winner)*BE_WIDTH +: BE_WIDTH];
      mem_writedata  = cl_writedata[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign accept = winValid & ~mem_waitrequest;
  assign push   = accept & mem_read;

  // An empty FIFO with a same-cycle push bypasses the winner's tag straight to the pop side.
  assign headTag = fifoEmpty ? winner : tagMem_q[rdPtr_q];
  assign pop     = mem_readdataready & ~reset & (~fifoEmpty | push);

  always_comb begin
    cl_readdataready = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cl_waitrequest[i]   = ~(winValid && (winner == PW'(i))) | mem_waitrequest;
      cl_readdataready[i] = pop && (headTag == PW'(i));
    end
  end

  assign cl_readdata   = mem_readdata;
  assign pending_count = count_q;
  assign err_orphan    = orphan_q;

  always_comb begin
    lock_d     = lock_q;
    lockPort_d = lockPort_q;
    rrPtr_d    = rrPtr_q;
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    orphan_d   = orphan_q | (mem_readdataready & fifoEmpty & ~push);
    if (lock_q && !req[lockPort_q]) lock_d = 1'b0;
    if (winValid && mem_waitrequest) begin
      lock_d     = 1'b1;
      lockPort_d = winner;
    end
    if (accept) begin
      lock_d = 1'b0;
      if (PRIORITY_MODE == 0)
        rrPtr_d = (winner == PW'(NUM_PORTS - 1)) ? '0 : winner + PW'(1);
    end
    if (push) wrPtr_d = wrPtr_q + FW'(1);
    if (pop)  rdPtr_d = rdPtr_q + FW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rrPtr_q    <= '0;
      lock_q     <= 1'b0;
      lockPort_q <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      orphan_q   <= 1'b0;
      for (int i = 0; i < MAX_PENDING; i++) tagMem_q[i] <= '0;
    end else begin
      rrPtr_q    <= rrPtr_d;
      lock_q     <= lock_d;
      lockPort_q <= lockPort_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      orphan_q   <= orphan_d;
      if (push) tagMem_q[wrPtr_q] <= winner;
    end
  end

endmodule

// File: tb/tb_mem_arb_n.sv
// Self-checking bench for mem_arb_n: a round-robin and a fixed-priority instance share stimulus;
// read returns are scored against a queue of expected destination ports.
module tb_mem_arb_n;

  localparam int NP = 3;
  localparam int AW = 20;
  localparam int DW = 16;
  localparam int BW = 2;
  localparam int MP = 4;
  localparam int CW = $clog2(MP + 1);

  logic clock = 1'b0;
  logic reset;
  logic [NP*AW-1:0] clAddress;
  logic [NP*BW-1:0] clBe;
  logic [NP-1:0]    clRead;
  logic [NP-1:0]    clWrite;
  logic [NP*DW-1:0] clWriteData;
  logic             memWait;
  logic [DW-1:0]    memRdata;
  logic             memRdy;

  logic [NP-1:0] rrWait, rrRdy, fpWait, fpRdy;
  logic [DW-1:0] rrRdata, fpRdata, rrMemWd, fpMemWd;
  logic [AW-1:0] rrMemAddr, fpMemAddr;
  logic [BW-1:0] rrMemBe, fpMemBe;
  logic          rrMemRd, rrMemWr, fpMemRd, fpMemWr;
  logic [CW-1:0] rrPend, fpPend;
  logic          rrOrphan, fpOrphan;

  int vecCount  = 0;
  int missCount = 0;
  int expAddr[$];
  int expPort[$];

  always #5 clock = ~clock;

  mem_arb_n #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW),
              .MAX_PENDING(MP), .PRIORITY_MODE(0)) dutRr (
    .clock(clock), .reset(reset),
    .cl_address(clAddress), .cl_byteenable(clBe), .cl_read(clRead), .cl_write(clWrite),
    .cl_writedata(clWriteData), .cl_waitrequest(rrWait), .cl_readdata(rrRdata),
    .cl_readdataready(rrRdy), .mem_address(rrMemAddr), .mem_byteenable(rrMemBe),
    .mem_read(rrMemRd), .mem_write(rrMemWr), .mem_writedata(rrMemWd),
    .mem_waitrequest(memWait), .mem_readdata(memRdata), .mem_readdataready(memRdy),
    .pending_count(rrPend), .err_orphan(rrOrphan)
  );

  mem_arb_n #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW),
              .MAX_PENDING(MP), .PRIORITY_MODE(1)) dutFp (
    .clock(clock), .reset(reset),
    .cl_address(clAddress), .cl_byteenable(clBe), .cl_read(clRead), .cl_write(clWrite),
    .cl_writedata(clWriteData), .cl_waitrequest(fpWait), .cl_readdata(fpRdata),
    .cl_readdataready(fpRdy), .mem_address(fpMemAddr), .mem_byteenable(fpMemBe),
    .mem_read(fpMemRd), .mem_write(fpMemWr), .mem_writedata(fpMemWd),
    .mem_waitrequest(memWait), .mem_readdata(memRdata), .mem_readdataready(memRdy),
    .pending_count(fpPend), .err_orphan(fpOrphan)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int p, input logic rd, input logic wr,
                               input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    clRead[p]             = rd;
    clWrite[p]            = wr;
    clAddress[p*AW +: AW] = addr;
    clWriteData[p*DW +: DW] = wd;
    clBe[p*BW +: BW]      = 2'b11;
  endtask

  task automatic clearAll();
    clRead      = '0;
    clWrite     = '0;
    clAddress   = '0;
    clWriteData = '0;
    clBe        = '0;
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
  endtask

  // Pops the next expected destination and compares the one-hot readdataready strobe.
  task automatic checkReturn(input string tag);
    logic [31:0] exp;
    exp = 0;
    if (expPort.size() > 0) exp = 32'(1) << expPort.pop_front();
    checkOutput(tag, 32'(rrRdy), exp);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int order[4];
    order = '{2, 0, 1, 0};
    reset = 1'b1;
    clearAll();
    memWait  = 1'b0;
    memRdy   = 1'b0;
    memRdata = '0;

    // Reset holds outputs idle even while a client requests.
    applyStimulus(0, 1'b0, 1'b1, 20'h00055, 16'h1234);
    @(negedge clock);
    checkOutput("rst_wait",  32'(rrWait), 32'h7);
    checkOutput("rst_mwr",   32'(rrMemWr), 32'h0);
    checkOutput("rst_addr",  32'(rrMemAddr), 32'h0);
    checkOutput("rst_pend",  32'(rrPend), 32'h0);
    checkOutput("rst_orph",  32'(rrOrphan), 32'h0);
    checkOutput("rst_rdy",   32'(rrRdy), 32'h0);
    nextCycle();
    reset = 1'b0;
    clearAll();

    // Round-robin fairness with continuous writes on all ports.
    for (int p = 0; p < NP; p++) applyStimulus(p, 1'b0, 1'b1, AW'(32'h100 + p), DW'(32'h1000 + p));
    for (int k = 0; k < 6; k++) expAddr.push_back(32'h100 + (k % NP));
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      checkOutput("rr_addr", 32'(rrMemAddr), 32'(expAddr.pop_front()));
      checkOutput("rr_wait", 32'(rrWait), 32'((~(3'b001 << (k % NP))) & 3'b111));
      checkOutput("rr_wdata", 32'(rrMemWd), 32'h1000 + (k % NP));
      checkOutput("fp_addr_all", 32'(fpMemAddr), 32'h100);
      nextCycle();
    end

    // Fixed priority: ports 1 and 2 request, port 0 joins on the third cycle.
    clearAll();
    applyStimulus(1, 1'b0, 1'b1, 20'h201, 16'h2001);
    applyStimulus(2, 1'b0, 1'b1, 20'h202, 16'h2002);
    for (int c = 0; c < 4; c++) begin
      if (c == 2) applyStimulus(0, 1'b0, 1'b1, 20'h200, 16'h2000);
      expAddr.push_back((c < 2) ? 32'h201 : 32'h200);
      @(negedge clock);
      checkOutput("fp_addr", 32'(fpMemAddr), 32'(expAddr.pop_front()));
      checkOutput("fp_starve2", 32'(fpWait[2]), 32'h1);
      nextCycle();
    end

    // Sticky grant: port 1 holds the bus through three stall cycles.
    clearAll();
    pulseReset();
    memWait = 1'b1;
    applyStimulus(1, 1'b0, 1'b1, 20'h301, 16'h3001);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) applyStimulus(0, 1'b0, 1'b1, 20'h300, 16'h3000);
      @(negedge clock);
      checkOutput("stk_addr", 32'(rrMemAddr), 32'h301);
      checkOutput("stk_wait", 32'(rrWait), 32'h7);
      nextCycle();
    end
    memWait = 1'b0;
    @(negedge clock);
    checkOutput("stk_acc_addr", 32'(rrMemAddr), 32'h301);
    checkOutput("stk_acc_wait", 32'(rrWait), 32'h5);
    nextCycle();
    @(negedge clock);
    checkOutput("stk_next_addr", 32'(rrMemAddr), 32'h300);
    nextCycle();

    // Read routing: fill the tag FIFO from ports 2,0,1,0.
    clearAll();
    pulseReset();
    for (int i = 0; i < 4; i++) begin
      clearAll();
      applyStimulus(order[i], 1'b1, 1'b0, AW'(32'h500 + order[i]), 16'h0);
      expPort.push_back(order[i]);
      @(negedge clock);
      checkOutput("rd_issue", 32'(rrMemRd), 32'h1);
      checkOutput("rd_addr", 32'(rrMemAddr), 32'h500 + order[i]);
      nextCycle();
    end
    clearAll();
    applyStimulus(1, 1'b1, 1'b0, 20'h501, 16'h0);
    applyStimulus(0, 1'b0, 1'b1, 20'h400, 16'h4000);
    @(negedge clock);
    checkOutput("full_pend", 32'(rrPend), 32'h4);
    checkOutput("full_wait", 32'(rrWait), 32'h6);
    checkOutput("full_wr", 32'(rrMemWr), 32'h1);
    checkOutput("full_waddr", 32'(rrMemAddr), 32'h400);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, 20'h0, 16'h0);
    @(negedge clock);
    checkOutput("full_block", 32'(rrWait), 32'h7);
    checkOutput("full_noread", 32'(rrMemRd), 32'h0);
    nextCycle();
    memRdy   = 1'b1;
    memRdata = 16'hA000;
    @(negedge clock);
    checkReturn("ret_0");
    checkOutput("ret_0_data", 32'(rrRdata), 32'hA000);
    checkOutput("ret_0_block", 32'(rrWait), 32'h7);
    nextCycle();
    memRdata = 16'hA001;
    expPort.push_back(1);
    @(negedge clock);
    checkReturn("ret_1");
    checkOutput("ret_1_grant", 32'(rrWait), 32'h5);
    checkOutput("ret_1_addr", 32'(rrMemAddr), 32'h501);
    nextCycle();
    clearAll();
    for (int i = 0; i < 3; i++) begin
      memRdata = DW'(32'hA002 + i);
      @(negedge clock);
      checkReturn("ret_tail");
      checkOutput("ret_tail_data", 32'(rrRdata), 32'hA002 + i);
      nextCycle();
    end
    memRdy = 1'b0;
    @(negedge clock);
    checkOutput("drain_pend", 32'(rrPend), 32'h0);
    checkOutput("drain_orph", 32'(rrOrphan), 32'h0);
    nextCycle();

    // Orphan data with nothing outstanding.
    memRdy   = 1'b1;
    memRdata = 16'hBEEF;
    @(negedge clock);
    checkOutput("orph_rdy", 32'(rrRdy), 32'h0);
    checkOutput("orph_pre", 32'(rrOrphan), 32'h0);
    nextCycle();
    memRdy = 1'b0;
    @(negedge clock);
    checkOutput("orph_set", 32'(rrOrphan), 32'h1);
    checkOutput("orph_pend", 32'(rrPend), 32'h0);
    nextCycle();

    // Simultaneous push and pop with one read outstanding.
    applyStimulus(2, 1'b1, 1'b0, 20'h602, 16'h0);
    expPort.push_back(2);
    @(negedge clock);
    checkOutput("pp_issue", 32'(rrMemRd), 32'h1);
    nextCycle();
    clearAll();
    applyStimulus(0, 1'b1, 1'b0, 20'h600, 16'h0);
    memRdy = 1'b1;
    expPort.push_back(0);
    @(negedge clock);
    checkReturn("pp_head");
    checkOutput("pp_issue2", 32'(rrMemRd), 32'h1);
    nextCycle();
    clearAll();
    memRdy = 1'b0;
    @(negedge clock);
    checkOutput("pp_pend", 32'(rrPend), 32'h1);
    nextCycle();
    memRdy = 1'b1;
    @(negedge clock);
    checkReturn("pp_last");
    nextCycle();
    memRdy = 1'b0;
    @(negedge clock);
    checkOutput("pp_drain", 32'(rrPend), 32'h0);
    checkOutput("orph_sticky", 32'(rrOrphan), 32'h1);
    nextCycle();

    // Reset mid-operation: two reads pending and a locked write.
    applyStimulus(0, 1'b1, 1'b0, 20'h700, 16'h0);
    nextCycle();
    clearAll();
    applyStimulus(1, 1'b1, 1'b0, 20'h701, 16'h0);
    nextCycle();
    clearAll();
    memWait = 1'b1;
    applyStimulus(2, 1'b0, 1'b1, 20'h702, 16'h7002);
    nextCycle();
    @(negedge clock);
    checkOutput("mid_lock_addr", 32'(rrMemAddr), 32'h702);
    checkOutput("mid_pend", 32'(rrPend), 32'h2);
    #2;
    reset  = 1'b1;
    memRdy = 1'b1;
    #1;
    checkOutput("mid_rst_wait", 32'(rrWait), 32'h7);
    checkOutput("mid_rst_wr", 32'(rrMemWr), 32'h0);
    checkOutput("mid_rst_addr", 32'(rrMemAddr), 32'h0);
    checkOutput("mid_rst_pend", 32'(rrPend), 32'h0);
    checkOutput("mid_rst_rdy", 32'(rrRdy), 32'h0);
    checkOutput("mid_rst_orph", 32'(rrOrphan), 32'h0);
    clearAll();
    memWait = 1'b0;
    memRdy  = 1'b0;
    expPort.delete();
    nextCycle();
    reset = 1'b0;
    applyStimulus(0, 1'b1, 1'b0, 20'h800, 16'h0);
    expPort.push_back(0);
    @(negedge clock);
    checkOutput("post_rd", 32'(rrMemRd), 32'h1);
    checkOutput("post_addr", 32'(rrMemAddr), 32'h800);
    nextCycle();
    clearAll();
    memRdy = 1'b1;
    @(negedge clock);
    checkReturn("post_ret");
    nextCycle();
    memRdy = 1'b0;
    @(negedge clock);
    checkOutput("post_pend", 32'(rrPend), 32'h0);
    checkOutput("sb_leftover", 32'(expPort.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
